branch_predictor_unit: RTL and testbench
========================================

// Module: branch_predictor_unit
// PURPOSE
//  Parametrised fetch-stage branch predictor: gshare PHT + direct-mapped BTB + speculative global history
//  with checkpoint repair. Predicts direction and target in F (combinational, same cycle as PC_F);
//  trains from resolved branches in EX. Replaces the fixed-size gshare/fetch-decoder pair in the core's
//  PC-select path; pred_target_F feeds the PC mux, ghr_snap_F travels down the pipe registers to EX.
// PARAMETERS
//  PC_W      32  program counter width
//  GHR_W     8   global history length (bits); GHR_W <= PHT_IDX_W
//  PHT_IDX_W 10  log2(PHT entries); entries hold 2-bit saturating counters
//  BTB_IDX_W 6   log2(BTB entries); tag = PC[PC_W-1:BTB_IDX_W+2]
// PORTS
//  clk            in  1         clock, rising edge
//  rst            in  1         asynchronous, active-low reset
//  ready          out 1         1 = init sweep done, predictions valid
//  fetch_valid_F  in  1         PC_F holds a real fetch this cycle
//  stall_F        in  1         fetch stalled; no speculative history update
//  PC_F           in  PC_W      fetch PC
//  pred_taken_F   out 1         predict taken (BTB hit AND counter MSB)
//  pred_target_F  out PC_W      BTB target; 0 when no BTB hit
//  btb_hit_F      out 1         BTB valid entry with matching tag
//  ghr_snap_F     out GHR_W     GHR value used for this lookup (checkpoint)
//  upd_valid_EX   in  1         a conditional branch resolved in EX
//  PC_EX          in  PC_W      PC of resolving branch
//  taken_EX       in  1         actual direction
//  target_EX      in  PC_W      actual taken target
//  ghr_snap_EX    in  GHR_W     checkpoint carried from F
//  mispredict_EX  in  1         direction or target mispredicted (asserted only with upd_valid_EX)
// BEHAVIOUR
//  Reset (rst=0, async): state INIT, init_ptr=0, GHR=0, all BTB valid=0, ready=0,
//   pred_taken_F=0, pred_target_F=0, btb_hit_F=0; ghr_snap_F = GHR = 0.
//  FSM INIT: each cycle writes PHT[init_ptr]=2'b01 (weakly not-taken), init_ptr++; after entry
//   2^PHT_IDX_W-1 -> RUN next cycle; ready=1 from that cycle. INIT lasts exactly 2^PHT_IDX_W cycles.
//   In INIT: predictions forced 0, updates and GHR shifts ignored. RUN has no exit except reset.
//  Lookup (RUN, combinational): pht_idx = PC_F[PHT_IDX_W+1:2] ^ {{PHT_IDX_W-GHR_W{0}},GHR};
//   btb_idx = PC_F[BTB_IDX_W+1:2]; hit = valid & tag match; pred_taken_F = hit & PHT[pht_idx][1].
//  Speculative GHR: on fetch_valid_F & !stall_F & btb_hit_F & !mispredict_EX:
//   GHR <= {GHR[GHR_W-2:0], pred_taken_F}. Non-branch fetches (no hit) leave GHR unchanged.
//  Update (RUN, upd_valid_EX): idx = PC_EX[PHT_IDX_W+1:2] ^ ghr_snap_EX;
//   counter saturates: taken & ctr!=3 -> +1; !taken & ctr!=0 -> -1; else hold.
//   taken_EX: BTB[PC_EX idx] <= {valid=1, tag, target_EX} (overwrite on conflict). !taken: BTB unchanged.
//  Repair: mispredict_EX -> GHR <= {ghr_snap_EX[GHR_W-2:0], taken_EX}; has priority over same-cycle
//   speculative shift (F instruction is on the wrong path and is flushed by the hazard unit).
//  Same-entry read/write in one cycle: F lookup sees old PHT/BTB contents (write takes effect next edge).
//  Counter and index arithmetic is modular; init_ptr wraps only at INIT->RUN.
//  Reset mid-operation: all state returns to reset values; INIT sweep restarts from 0.
// STRUCTURE
//  Package bp_pkg: typedef enum logic {BP_INIT, BP_RUN} bp_state_t; typedef logic [1:0] sat_ctr_t;
//   constants CTR_WEAK_NT=2'b01, CTR_MAX=2'b11; btb_entry_t struct {valid, tag, target}.
//  Sub-module bp_sat_counter: 2-bit saturating next-value function (combinational, reused by PHT update).
//  PHT as plain register array (no async reset; cleared by INIT sweep); BTB valid bits async-reset.
// TESTING (PHT_IDX_W=4, GHR_W=4, BTB_IDX_W=2 for bench speed)
//  1 Reset release -> ready=0 for 16 cycles then 1; all lookups pred_taken_F=0, btb_hit_F=0 meanwhile.
//  2 Train PC 0x40 taken, target 0x20, snap 0, twice -> counter 01->10->11; fetch 0x40 with GHR=0
//    -> btb_hit_F=1, pred_taken_F=1, pred_target_F=0x20.
//  3 Five not-taken updates on same index from 11 -> saturates at 00; extra decrement holds 00.
//  4 GHR=4'b1010, hit predicted taken, no stall -> GHR=4'b0101; same with stall_F=1 -> GHR unchanged.
//  5 Speculative shift and mispredict_EX (snap 4'b0011, taken_EX=0) same cycle -> GHR=4'b0110.
//  6 Assert rst mid-RUN after training -> BTB empty, GHR=0, ready=0, INIT sweep repeats 16 cycles.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
// Counter encodings, FSM states and the BTB entry view.
package bp_pkg;

  typedef enum logic {BP_INIT, BP_RUN} bp_state_t;

  typedef logic [1:0] sat_ctr_t;

  localparam sat_ctr_t CTR_MIN     = 2'b00;
  localparam sat_ctr_t CTR_WEAK_NT = 2'b01;
  localparam sat_ctr_t CTR_MAX     = 2'b11;

  localparam int BP_PC_MAX = 32;

  typedef struct packed {
    logic                 valid;
    logic [BP_PC_MAX-1:0] tag;
    logic [BP_PC_MAX-1:0] target;
  } btb_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-value function.
// Pure combinational; used by the PHT training path.
import bp_pkg::*;

module bp_sat_counter (
  input  sat_ctr_t ctr,
  input  logic     taken,
  output sat_ctr_t nxt
);

  // step toward the resolved direction, clamp at both ends
  always_comb begin
    nxt = ctr;
    unique case (1'b1)
      taken && (ctr != CTR_MAX):  nxt = ctr + 2'd1;
      !taken && (ctr != CTR_MIN): nxt = ctr - 2'd1;
      default:                    nxt = ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor_unit.sv
// gshare PHT + direct-mapped BTB with speculative GHR and repair.
// Lookup is combinational in F; training happens from EX.
import bp_pkg::*;

module branch_predictor_unit #(
  parameter int PC_W      = 32,
  parameter int GHR_W     = 8,
  parameter int PHT_IDX_W = 10,
  parameter int BTB_IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic             fetch_valid_F,
  input  logic             stall_F,
  input  logic [PC_W-1:0]  PC_F,
  output logic             pred_taken_F,
  output logic [PC_W-1:0]  pred_target_F,
  output logic             btb_hit_F,
  output logic [GHR_W-1:0] ghr_snap_F,
  input  logic             upd_valid_EX,
  input  logic [PC_W-1:0]  PC_EX,
  input  logic             taken_EX,
  input  logic [PC_W-1:0]  target_EX,
  input  logic [GHR_W-1:0] ghr_snap_EX,
  input  logic             mispredict_EX
);

  localparam int PHT_N   = 1 << PHT_IDX_W;
  localparam int BTB_N   = 1 << BTB_IDX_W;
  localparam int TAG_LSB = BTB_IDX_W + 2;
  localparam int TAG_W   = PC_W - TAG_LSB;

  bp_state_t state_q, state_d;
  logic [PHT_IDX_W-1:0] init_ptr_q, init_ptr_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;

  sat_ctr_t pht [PHT_N];
  logic [BTB_N-1:0] btb_valid_q;
  logic [TAG_W-1:0] btb_tag [BTB_N];
  logic [PC_W-1:0] btb_tgt [BTB_N];

  logic run;
  assign run = (state_q == BP_RUN);

  logic [PHT_IDX_W-1:0] f_pht_idx, ex_pht_idx;
  logic [BTB_IDX_W-1:0] f_btb_idx, ex_btb_idx;
  logic [TAG_W-1:0] f_tag, ex_tag;

  assign f_pht_idx  = PC_F[PHT_IDX_W+1:2]
                    ^ PHT_IDX_W'(ghr_q);
  assign f_btb_idx  = PC_F[BTB_IDX_W+1:2];
  assign f_tag      = PC_F[PC_W-1:TAG_LSB];

  assign ex_pht_idx = PC_EX[PHT_IDX_W+1:2]
                    ^ PHT_IDX_W'(ghr_snap_EX);
  assign ex_btb_idx = PC_EX[BTB_IDX_W+1:2];
  assign ex_tag     = PC_EX[PC_W-1:TAG_LSB];

  logic unused_lsb;
  assign unused_lsb = ^{PC_F[1:0], PC_EX[1:0]};

  btb_entry_t f_ent;
  logic f_hit;

  // assemble the indexed BTB entry for the F lookup
  always_comb begin
    f_ent.valid  = btb_valid_q[f_btb_idx];
    f_ent.tag    = BP_PC_MAX'(btb_tag[f_btb_idx]);
    f_ent.target = BP_PC_MAX'(btb_tgt[f_btb_idx]);
  end

  assign f_hit = run && f_ent.valid
              && (f_ent.tag == BP_PC_MAX'(f_tag));

  assign btb_hit_F     = f_hit;
  assign pred_taken_F  = f_hit && pht[f_pht_idx][1];
  assign pred_target_F = f_hit ? PC_W'(f_ent.target) : '0;
  assign ghr_snap_F    = ghr_q;
  assign ready         = run;

  sat_ctr_t ex_ctr, ex_ctr_nxt;
  assign ex_ctr = pht[ex_pht_idx];

  bp_sat_counter u_ctr (
    .ctr   (ex_ctr),
    .taken (taken_EX),
    .nxt   (ex_ctr_nxt)
  );

  logic do_upd, btb_wr;
  assign do_upd = run && upd_valid_EX;
  assign btb_wr = do_upd && taken_EX;

  // PHT: swept to weak-NT during INIT, trained in RUN
  always_ff @(posedge clk) begin
    if (!run)
      pht[init_ptr_q] <= CTR_WEAK_NT;
    else if (upd_valid_EX)
      pht[ex_pht_idx] <= ex_ctr_nxt;
  end

  // BTB valid bits are the only BTB state that needs reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      btb_valid_q <= '0;
    else if (btb_wr)
      btb_valid_q[ex_btb_idx] <= 1'b1;
  end

  // BTB tag/target payload, overwritten on taken resolve
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag[ex_btb_idx] <= ex_tag;
      btb_tgt[ex_btb_idx] <= target_EX;
    end
  end

  // state, sweep pointer and history registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BP_INIT;
      init_ptr_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ghr_q      <= ghr_d;
    end
  end

  // INIT sweeps every PHT entry once, then RUN forever
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    unique case (state_q)
      BP_INIT: begin
        init_ptr_d = init_ptr_q + PHT_IDX_W'(1);
        if (&init_ptr_q)
          state_d = BP_RUN;
      end
      BP_RUN:  state_d = BP_RUN;
      default: state_d = BP_INIT;
    endcase
  end

  logic spec_shift;
  assign spec_shift = fetch_valid_F && !stall_F
                   && f_hit && !mispredict_EX;

  // repair from EX beats the wrong-path speculative shift
  always_comb begin
    ghr_d = ghr_q;
    unique case (1'b1)
      run && mispredict_EX:
        ghr_d = {ghr_snap_EX[GHR_W-2:0], taken_EX};
      spec_shift:
        ghr_d = {ghr_q[GHR_W-2:0], pred_taken_F};
      default:
        ghr_d = ghr_q;
    endcase
  end

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed bench for branch_predictor_unit.
// Small geometry: 16-entry PHT, 4-bit GHR, 4-entry BTB.
module tb_branch_predictor_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        fetch_valid_F;
  logic        stall_F;
  logic [31:0] PC_F;
  logic        pred_taken_F;
  logic [31:0] pred_target_F;
  logic        btb_hit_F;
  logic [3:0]  ghr_snap_F;
  logic        upd_valid_EX;
  logic [31:0] PC_EX;
  logic        taken_EX;
  logic [31:0] target_EX;
  logic [3:0]  ghr_snap_EX;
  logic        mispredict_EX;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  branch_predictor_unit #(
    .PC_W      (32),
    .GHR_W     (4),
    .PHT_IDX_W (4),
    .BTB_IDX_W (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ready         (ready),
    .fetch_valid_F (fetch_valid_F),
    .stall_F       (stall_F),
    .PC_F          (PC_F),
    .pred_taken_F  (pred_taken_F),
    .pred_target_F (pred_target_F),
    .btb_hit_F     (btb_hit_F),
    .ghr_snap_F    (ghr_snap_F),
    .upd_valid_EX  (upd_valid_EX),
    .PC_EX         (PC_EX),
    .taken_EX      (taken_EX),
    .target_EX     (target_EX),
    .ghr_snap_EX   (ghr_snap_EX),
    .mispredict_EX (mispredict_EX)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc,
                     input logic        tk,
                     input logic [31:0] tgt,
                     input logic [3:0]  snap,
                     input logic        mp);
    upd_valid_EX  = 1'b1;
    PC_EX         = pc;
    taken_EX      = tk;
    target_EX     = tgt;
    ghr_snap_EX   = snap;
    mispredict_EX = mp;
    tick;
    upd_valid_EX  = 1'b0;
    taken_EX      = 1'b0;
    mispredict_EX = 1'b0;
  endtask

  task automatic wait_ready(inout int n);
    while (!ready && n < 40) begin
      tick;
      n++;
    end
  endtask

  initial begin
    int n;
    logic quiet;
    logic [4:0] exp_nt;

    rst           = 1'b0;
    fetch_valid_F = 1'b0;
    stall_F       = 1'b0;
    PC_F          = 32'h40;
    upd_valid_EX  = 1'b0;
    PC_EX         = 32'h0;
    taken_EX      = 1'b0;
    target_EX     = 32'h0;
    ghr_snap_EX   = 4'h0;
    mispredict_EX = 1'b0;

    tick;
    tick;
    check("rst_ready", ready, 0);
    check("rst_hit", btb_hit_F, 0);
    check("rst_taken", pred_taken_F, 0);
    check("rst_target", pred_target_F, 0);
    check("rst_ghr", ghr_snap_F, 0);

    // sweep: fetches and taken updates must be ignored
    rst           = 1'b1;
    fetch_valid_F = 1'b1;
    quiet         = 1'b0;
    n             = 0;
    for (int i = 0; i < 4; i++) begin
      upd_valid_EX = 1'b1;
      PC_EX        = 32'h40;
      taken_EX     = 1'b1;
      target_EX    = 32'h99;
      quiet |= ready | btb_hit_F | pred_taken_F
             | (pred_target_F != 0);
      tick;
      n++;
    end
    upd_valid_EX  = 1'b0;
    taken_EX      = 1'b0;
    fetch_valid_F = 1'b0;
    quiet |= ready | btb_hit_F | pred_taken_F;
    check("init_quiet", quiet, 0);
    wait_ready(n);
    check("init_len", n, 16);
    check("init_no_train", btb_hit_F, 0);
    check("init_ghr", ghr_snap_F, 0);

    // train 0x40 taken -> 0x20, lookup same cycle sees old
    PC_F          = 32'h40;
    upd_valid_EX  = 1'b1;
    PC_EX         = 32'h40;
    taken_EX      = 1'b1;
    target_EX     = 32'h20;
    ghr_snap_EX   = 4'h0;
    #1;
    check("same_cycle_old", btb_hit_F, 0);
    tick;
    upd_valid_EX  = 1'b0;
    taken_EX      = 1'b0;
    check("t1_hit", btb_hit_F, 1);
    check("t1_taken", pred_taken_F, 1);
    upd(32'h40, 1'b1, 32'h20, 4'h0, 1'b0);
    check("t2_hit", btb_hit_F, 1);
    check("t2_taken", pred_taken_F, 1);
    check("t2_target", pred_target_F, 32'h20);

    // 11 -> 10 -> 01 -> 00 -> 00 -> 00
    exp_nt = 5'b00001;
    for (int k = 0; k < 5; k++) begin
      upd(32'h40, 1'b0, 32'h0, 4'h0, 1'b0);
      check($sformatf("nt%0d_taken", k + 1),
            pred_taken_F, exp_nt[k]);
    end
    check("nt_btb_kept", pred_target_F, 32'h20);
    upd(32'h40, 1'b1, 32'h20, 4'h0, 1'b0);
    check("sat_low_taken", pred_taken_F, 0);
    check("sat_low_hit", btb_hit_F, 1);

    PC_F = 32'h80;
    #1;
    check("miss_hit", btb_hit_F, 0);
    check("miss_target", pred_target_F, 0);
    check("miss_taken", pred_taken_F, 0);

    // set GHR = 1010 via repair
    upd(32'h100, 1'b0, 32'h0, 4'b0101, 1'b1);
    check("repair_ghr", ghr_snap_F, 4'b1010);
    upd(32'h40, 1'b1, 32'h20, 4'b1010, 1'b0);
    upd(32'h40, 1'b1, 32'h20, 4'b1010, 1'b0);
    check("train_ghr_kept", ghr_snap_F, 4'b1010);

    PC_F          = 32'h40;
    fetch_valid_F = 1'b1;
    stall_F       = 1'b1;
    #1;
    check("g_taken", pred_taken_F, 1);
    tick;
    check("stall_ghr", ghr_snap_F, 4'b1010);
    stall_F = 1'b0;
    tick;
    check("shift_ghr", ghr_snap_F, 4'b0101);
    fetch_valid_F = 1'b0;

    // speculative shift and repair in the same cycle
    fetch_valid_F = 1'b1;
    #1;
    check("pri_hit", btb_hit_F, 1);
    upd(32'h200, 1'b0, 32'h0, 4'b0011, 1'b1);
    check("pri_ghr", ghr_snap_F, 4'b0110);
    fetch_valid_F = 1'b0;

    PC_F          = 32'h80;
    fetch_valid_F = 1'b1;
    tick;
    check("nonbr_ghr", ghr_snap_F, 4'b0110);
    fetch_valid_F = 1'b0;

    // reset mid-run
    PC_F = 32'h40;
    rst  = 1'b0;
    #1;
    check("mid_rst_ready", ready, 0);
    check("mid_rst_ghr", ghr_snap_F, 0);
    check("mid_rst_hit", btb_hit_F, 0);
    tick;
    tick;
    rst = 1'b1;
    n   = 0;
    wait_ready(n);
    check("reinit_len", n, 16);
    check("reinit_btb", btb_hit_F, 0);
    check("reinit_target", pred_target_F, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
